reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset-release controller for multi-domain designs. It synchronizes `reset_async` internally with async assert and synchronous deassert, holds every domain in reset for a fixed settle time, then releases domains one at a time in index order, waiting for each domain's ready acknowledge before releasing the next. It sits at the top of the clock/reset tree, between the board/PLL reset and the per-domain reset inputs, and also services software-initiated full resets.

## Interface
- `NUM_DOMAINS`, 4: number of sequenced reset domains (≥2).
- `SYNC_STAGE`, 2: depth of the internal reset synchronizer (≥2).
- `HOLD_CYCLES`, 8: cycles all domains are held in reset after the synchronized reset deasserts (≥1).
- `TIMEOUT_CYCLES`, 64: maximum wait per domain for `domain_ready` (≥1; used only with the timeout feature).

Ports:
- `clk`  in  1  sequencer clock.
- `reset_async`  in  1  reset; asynchronous, active-high; clock `clk`.
- `sw_reset_req`  in  1  single-cycle, `clk`-synchronous software reset request.
- `domain_ready`  in  NUM_DOMAINS  per-domain acknowledge, already in the `clk` domain.
- `domain_reset`  out  NUM_DOMAINS  per-domain reset, active-high, registered.
- `all_released`  out  1  high when every domain is released.
- `busy`  out  1  high while a sequence is in progress (HOLD or WAIT).
- `timeout_err`  out  1  sticky flag: a domain failed to acknowledge in time.

## Operation
- The internal synchronizer is a `SYNC_STAGE`-deep shift chain.
  - It asserts asynchronously with `reset_async`.
  - It deasserts synchronously.
  - While its output is high, the FSM is forced to HOLD with counters cleared.
- FSM states:
  - **HOLD**: all `domain_reset`=1. A hold counter runs from 0. When it reaches HOLD_CYCLES-1, the FSM clears `domain_reset[0]`, sets index=0 and goes to WAIT.
  - **WAIT(i)**: `domain_reset[0..i]`=0 and the rest are 1. A wait counter runs.
    - If `domain_ready[i]` is sampled 1 and i<NUM_DOMAINS-1: clear `domain_reset[i+1]`, increment i, clear the wait counter.
    - If `domain_ready[i]` is sampled 1 and i=NUM_DOMAINS-1: go to DONE.
  - **DONE**: all `domain_reset`=0, `all_released`=1, `busy`=0. `domain_ready` is ignored, so a later drop in ready has no effect.
- `sw_reset_req`=1 in any state:
  - On that edge, all `domain_reset`<=1, state<=HOLD, counters cleared, `all_released`<=0, `busy`<=1.
  - `timeout_err` is unchanged.
- Priority: synchronized reset > `sw_reset_req` > `domain_ready`/timeout.
- Reset values (while the synchronized reset is high):
  - `domain_reset`=all 1s, `all_released`=0, `busy`=1, `timeout_err`=0.
- `timeout_err` clears only via `reset_async`.
- Counter widths are `$clog2` of their limit plus 1. Counters saturate and never wrap.

## Timing
- `reset_async` assertion sets all `domain_reset`=1 asynchronously, with no clock needed.
- After `reset_async` falls:
  - The synchronized reset falls on the SYNC_STAGE-th rising edge.
  - `domain_reset[0]` falls on edge SYNC_STAGE+HOLD_CYCLES. With defaults this is edge 10.
- Ack to next release: `domain_reset[i+1]` falls on the same edge that samples `domain_ready[i]`=1, a 1-cycle response.
- `all_released` rises on the edge that samples `domain_ready[NUM_DOMAINS-1]`=1.
- `sw_reset_req` to reassert takes 1 edge. Release after a `sw_reset_req` restarts at HOLD: `domain_reset[0]` falls HOLD_CYCLES edges after the request edge.
- `sw_reset_req` and `domain_ready` high on the same edge: the request wins and no release occurs.
- `domain_ready[i]` already high on entry to WAIT(i) advances on the next edge. There is no minimum release width beyond 1 cycle.

## Configuration
- Macro `RESET_SEQ_TIMEOUT_EN`.
- Defined: if WAIT(i) spends TIMEOUT_CYCLES edges without `domain_ready[i]`, the FSM sets `timeout_err`<=1 and advances exactly as if acknowledged.
- Undefined:
  - WAIT(i) waits indefinitely.
  - `timeout_err` is tied 0.
  - No wait counter is built.

## Test plan
- Power-on sequence:
  - Stimulus: assert `reset_async` for 5 cycles, release it, and drive each `domain_ready[i]` high 3 cycles after `domain_reset[i]` falls.
  - Required response: `domain_reset[0]` falls at edge 10; falls are staggered 3 edges apart; `all_released`=1 at edge 22.
- Out-of-order ready:
  - Stimulus: hold `domain_ready`=4'b1110.
  - Required response: only `domain_reset[0]` releases, with `busy`=1 indefinitely (timeout disabled).
  - Stimulus: then raise `domain_ready[0]`.
  - Required response: domains 1–3 release on consecutive edges.
- Software reset in DONE:
  - Stimulus: pulse `sw_reset_req`.
  - Required response: `domain_reset`=4'b1111 on the next edge, `all_released`=0; `domain_reset[0]` falls 8 edges after the request.
- Mid-sequence async reset and collision:
  - Stimulus: assert `reset_async` during WAIT(2).
  - Required response: immediate `domain_reset`=4'b1111 with no clock edge.
  - Stimulus: `sw_reset_req` coincident with `domain_ready[1]`.
  - Required response: the request wins.
- Timeout, with `RESET_SEQ_TIMEOUT_EN` defined:
  - Stimulus: `domain_ready[1]` is stuck at 0.
  - Required response: 64 edges after `domain_reset[1]` falls, `timeout_err`=1 and `domain_reset[2]` falls.
  - Stimulus: `sw_reset_req`.
  - Required response: `timeout_err` is still 1.

Source files
------------

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
//
// Staged reset-release controller. The board/PLL reset is synchronized
// internally (asynchronous assert, synchronous deassert). After it deasserts,
// every domain is held in reset for HOLD_CYCLES. The domains are then released
// one at a time in index order. The next domain is released only after the
// current domain acknowledges on domain_ready. A single-cycle sw_reset_req
// restarts the whole sequence from HOLD.
//
// Optional feature macro: RESET_SEQ_TIMEOUT_EN
//   defined   - a domain that does not acknowledge within TIMEOUT_CYCLES is
//               skipped, and the sticky timeout_err flag is set.
//   undefined - the sequencer waits for each acknowledge indefinitely, and
//               timeout_err is tied low.
//
// Ports
//   clk           in   sequencer clock
//   reset_async   in   asynchronous, active-high reset
//   sw_reset_req  in   single-cycle software full-reset request (clk domain)
//   domain_ready  in   [NUM_DOMAINS] per-domain release acknowledge
//   domain_reset  out  [NUM_DOMAINS] per-domain reset, active-high, registered
//   all_released  out  every domain is out of reset
//   busy          out  a sequence is in progress (HOLD or WAIT)
//   timeout_err   out  sticky: a domain failed to acknowledge in time
// ----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SYNC_STAGE     = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset_async,
    input  logic                   sw_reset_req,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   all_released,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int IDX_W  = $clog2(NUM_DOMAINS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Reset synchronizer: it sets asynchronously and shifts zeros in on clk.
    logic [SYNC_STAGE-1:0] r_sync;
    logic                  w_sync_rst;

    // NOTE: sequential state uses non-blocking (<=) assignments only, so every
    // flop samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) r_sync <= '1;
        else             r_sync <= {r_sync[SYNC_STAGE-2:0], 1'b0};
    end

    assign w_sync_rst = r_sync[SYNC_STAGE-1];

    state_t                 r_state,        w_state_nxt;
    logic [HOLD_W-1:0]      r_hold_cnt,     w_hold_cnt_nxt;
    logic [IDX_W-1:0]       r_idx,          w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_domain_reset, w_domain_reset_nxt;
    logic                   r_all_released, w_all_released_nxt;
    logic                   r_busy,         w_busy_nxt;
    logic                   w_ack;
    logic                   w_advance;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] r_wait_cnt,    w_wait_cnt_nxt;
    logic              r_timeout_err, w_timeout_err_nxt;
    logic              w_expired;
`else
    // TIMEOUT_CYCLES only matters when the timeout feature is built.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt        = r_state;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_idx_nxt          = r_idx;
        w_domain_reset_nxt = r_domain_reset;
        w_all_released_nxt = r_all_released;
        w_busy_nxt         = r_busy;
        w_ack              = domain_ready[r_idx];
        w_advance          = w_ack;
`ifdef RESET_SEQ_TIMEOUT_EN
        w_wait_cnt_nxt     = r_wait_cnt;
        w_timeout_err_nxt  = r_timeout_err;
        w_expired          = !w_ack && (r_wait_cnt >= WAIT_LAST);
        w_advance          = w_ack || w_expired;
`endif

        if (sw_reset_req) begin
            // The software request overrides any acknowledge on the same edge.
            // It leaves timeout_err untouched.
            w_state_nxt        = ST_HOLD;
            w_hold_cnt_nxt     = '0;
            w_idx_nxt          = '0;
            w_domain_reset_nxt = '1;
            w_all_released_nxt = 1'b0;
            w_busy_nxt         = 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
            w_wait_cnt_nxt     = '0;
`endif
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt >= HOLD_LAST) begin
                        w_state_nxt        = ST_WAIT;
                        w_idx_nxt          = '0;
                        w_domain_reset_nxt = {{(NUM_DOMAINS-1){1'b1}}, 1'b0};
`ifdef RESET_SEQ_TIMEOUT_EN
                        w_wait_cnt_nxt     = '0;
`endif
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (w_advance) begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        if (w_expired) w_timeout_err_nxt = 1'b1;
                        w_wait_cnt_nxt = '0;
`endif
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt        = ST_DONE;
                            w_all_released_nxt = 1'b1;
                            w_busy_nxt         = 1'b0;
                        end else begin
                            // Release the next domain on the same edge as the ack.
                            w_idx_nxt = r_idx + IDX_W'(1);
                            for (int d = 0; d < NUM_DOMAINS; d++) begin
                                if (d == int'(r_idx) + 1) w_domain_reset_nxt[d] = 1'b0;
                            end
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (r_wait_cnt < WAIT_LAST) begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    // domain_ready is ignored once every domain is released.
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                end
            endcase
        end
    end

    // reset_async clears everything immediately. The synchronized reset then
    // keeps the FSM parked in HOLD until its synchronous deassert.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async || w_sync_rst) begin
            r_state        <= ST_HOLD;
            r_hold_cnt     <= '0;
            r_idx          <= '0;
            r_domain_reset <= '1;
            r_all_released <= 1'b0;
            r_busy         <= 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
            r_wait_cnt     <= '0;
            r_timeout_err  <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_idx          <= w_idx_nxt;
            r_domain_reset <= w_domain_reset_nxt;
            r_all_released <= w_all_released_nxt;
            r_busy         <= w_busy_nxt;
`ifdef RESET_SEQ_TIMEOUT_EN
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_timeout_err  <= w_timeout_err_nxt;
`endif
        end
    end

    assign domain_reset = r_domain_reset;
    assign all_released = r_all_released;
    assign busy         = r_busy;
`ifdef RESET_SEQ_TIMEOUT_EN
    assign timeout_err  = r_timeout_err;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with the default parameters
// (4 domains, 2-stage synchronizer, 8 hold cycles, 64 timeout cycles).
// Each step pushes the expected output bundle into a scoreboard queue and
// advances one clock edge. The bench then pops that entry and compares it
// against the DUT outputs, sampled 1 time unit after the edge.
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_async;
    logic         sw_reset_req;
    logic [N-1:0] domain_ready;
    logic [N-1:0] domain_reset;
    logic         all_released;
    logic         busy;
    logic         timeout_err;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS    (N),
        .SYNC_STAGE     (2),
        .HOLD_CYCLES    (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .reset_async  (reset_async),
        .sw_reset_req (sw_reset_req),
        .domain_ready (domain_ready),
        .domain_reset (domain_reset),
        .all_released (all_released),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    typedef struct {
        string      tag;
        logic [6:0] val;   // {domain_reset, all_released, busy, timeout_err}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_terr = 1'b0;

    task automatic push_exp(input string tag, input logic [3:0] rst,
                            input logic rel, input logic bsy);
        exp_t e;
        e.tag = tag;
        e.val = {rst, rel, bsy, exp_terr};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [6:0] obs;
        obs = {domain_reset, all_released, busy, timeout_err};
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed=%b with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s: observed rst=%b rel=%b busy=%b terr=%b, expected rst=%b rel=%b busy=%b terr=%b",
                       e.tag, obs[6:3], obs[2], obs[1], obs[0],
                       e.val[6:3], e.val[2], e.val[1], e.val[0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] rst,
                        input logic rel, input logic bsy);
        push_exp(tag, rst, rel, bsy);
        tick();
        pop_check();
    endtask

    initial begin
        logic [3:0] er;

        reset_async  = 1'b1;
        sw_reset_req = 1'b0;
        domain_ready = '0;

        // Asynchronous reset state, before any clock edge.
        #1;
        push_exp("por_async", 4'b1111, 1'b0, 1'b1);
        pop_check();
        repeat (5) tick();

        // Power-on: releases on edges 10/13/16/19, each ready 3 edges later.
        reset_async = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            for (int i = 0; i < N; i++) er[i] = (n < 10 + 3 * i);
            step($sformatf("por_edge%0d", n), er, n >= 22, n < 22);
            if (n >= 12 && n <= 21 && (n - 12) % 3 == 0) domain_ready[(n - 12) / 3] = 1'b1;
        end

        // DONE ignores a later drop of ready.
        domain_ready = '0;
        for (int k = 1; k <= 3; k++) step($sformatf("done_ignore%0d", k), 4'b0000, 1'b1, 1'b0);

        // Software reset from DONE: reasserts in 1 edge, domain 0 releases 8 edges later.
        sw_reset_req = 1'b1;
        step("sw_done_req", 4'b1111, 1'b0, 1'b1);
        sw_reset_req = 1'b0;
        for (int k = 1; k <= 8; k++)
            step($sformatf("sw_done_hold%0d", k), (k < 8) ? 4'b1111 : 4'b1110, 1'b0, 1'b1);

        // Out-of-order ready: stalls in WAIT(0) until ready[0] arrives.
        domain_ready = 4'b1110;
        for (int k = 1; k <= 20; k++) step($sformatf("ooo_stall%0d", k), 4'b1110, 1'b0, 1'b1);
        domain_ready = 4'b1111;
        step("ooo_rel1", 4'b1100, 1'b0, 1'b1);
        step("ooo_rel2", 4'b1000, 1'b0, 1'b1);
        step("ooo_rel3", 4'b0000, 1'b0, 1'b1);
        step("ooo_done", 4'b0000, 1'b1, 1'b0);

        // Move into WAIT(2), then apply the async reset between edges.
        domain_ready = '0;
        sw_reset_req = 1'b1;
        step("sw2_req", 4'b1111, 1'b0, 1'b1);
        sw_reset_req = 1'b0;
        for (int k = 1; k <= 8; k++)
            step($sformatf("sw2_hold%0d", k), (k < 8) ? 4'b1111 : 4'b1110, 1'b0, 1'b1);
        domain_ready = 4'b0011;
        step("to_wait1", 4'b1100, 1'b0, 1'b1);
        step("to_wait2", 4'b1000, 1'b0, 1'b1);
        step("wait2_stall", 4'b1000, 1'b0, 1'b1);
        #2;
        reset_async = 1'b1;
        #1;
        push_exp("async_mid", 4'b1111, 1'b0, 1'b1);
        pop_check();
        repeat (2) tick();
        step("async_held", 4'b1111, 1'b0, 1'b1);

        // Release again; domain 0 falls on edge 10.
        reset_async  = 1'b0;
        domain_ready = '0;
        for (int n = 1; n <= 10; n++)
            step($sformatf("rel2_edge%0d", n), (n < 10) ? 4'b1111 : 4'b1110, 1'b0, 1'b1);
        domain_ready[0] = 1'b1;
        step("coll_wait1", 4'b1100, 1'b0, 1'b1);

        // sw_reset_req coincident with ready[1]: the request wins.
        sw_reset_req = 1'b1;
        domain_ready = 4'b0011;
        step("coll_req_wins", 4'b1111, 1'b0, 1'b1);
        sw_reset_req = 1'b0;
        for (int k = 1; k <= 8; k++)
            step($sformatf("coll_hold%0d", k), (k < 8) ? 4'b1111 : 4'b1110, 1'b0, 1'b1);
        step("coll_adv1", 4'b1100, 1'b0, 1'b1);
        step("coll_adv2", 4'b1000, 1'b0, 1'b1);

`ifdef RESET_SEQ_TIMEOUT_EN
        // domain_ready[1] stuck low: skipped 64 edges after domain 1 releases.
        domain_ready = 4'b0001;
        sw_reset_req = 1'b1;
        step("to_req", 4'b1111, 1'b0, 1'b1);
        sw_reset_req = 1'b0;
        for (int k = 1; k <= 8; k++)
            step($sformatf("to_hold%0d", k), (k < 8) ? 4'b1111 : 4'b1110, 1'b0, 1'b1);
        step("to_rel1", 4'b1100, 1'b0, 1'b1);
        for (int k = 1; k <= 63; k++) step($sformatf("to_wait%0d", k), 4'b1100, 1'b0, 1'b1);
        exp_terr = 1'b1;
        step("to_fire", 4'b1000, 1'b0, 1'b1);
        sw_reset_req = 1'b1;
        step("to_sticky_sw", 4'b1111, 1'b0, 1'b1);
        sw_reset_req = 1'b0;
        step("to_sticky_hold", 4'b1111, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
